// File: rtl/tv_fb_fetch.sv
// Framebuffer scan-out: prefetches 8-pixel words from a single-port video RAM,
// serialises them MSB-first at the pixel rate, and slots host writes into idle RAM cycles.
module tv_fb_fetch #(
  parameter int H_VISIBLE = 512,
  parameter int V_VISIBLE = 288,
  parameter int H_TOTAL   = 640,
  parameter int V_TOTAL   = 309,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              pix_ce,
  input  logic [9:0]        xpos,
  input  logic [8:0]        ypos,
  output logic              pixel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic              host_ack
);

  localparam int WORDS_PER_LINE = H_VISIBLE / 8;
  localparam int NUM_WORDS      = WORDS_PER_LINE * V_VISIBLE;

  localparam logic [ADDR_W-1:0] WPL_A       = ADDR_W'(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_WORDS);
  localparam logic [9:0]        WPL_X       = 10'(WORDS_PER_LINE);
  localparam logic [9:0]        H_VIS_X     = 10'(H_VISIBLE);
  localparam logic [9:0]        LAST_TRIG_X = 10'(H_TOTAL - 4);
  localparam logic [8:0]        V_VIS_Y     = 9'(V_VISIBLE);
  localparam logic [8:0]        LAST_LINE_Y = 9'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN_RD,
    SCAN_LAT,
    HOST_WR
  } state_e;

  state_e state_q, state_d;

  logic              scanPend_q, scanPend_d;
  logic [ADDR_W-1:0] scanAddr_q, scanAddr_d;
  logic [7:0]        nextWord_q, nextWord_d;
  logic [7:0]        shift_q, shift_d;
  logic              pixel_q, pixel_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic              ramWe_q, ramWe_d;
  logic [7:0]        ramWdata_q, ramWdata_d;
  logic              hostAck_q, hostAck_d;

  logic [9:0]        grpNext;
  logic [8:0]        nextLine;
  logic              trigger;
  logic [ADDR_W-1:0] trigAddr;
  logic              scanPendAny;
  logic [ADDR_W-1:0] pendAddr;
  logic              hostInRange;
  logic              visible;

  function automatic logic [ADDR_W-1:0] lineBase(input logic [8:0] y);
    return ADDR_W'(y) * WPL_A;
  endfunction

  // Fetch the group after the current one, or group 0 of the next line near line end.
  always_comb begin
    grpNext  = {3'b000, xpos[9:3]} + 10'd1;
    nextLine = (ypos == LAST_LINE_Y) ? 9'd0 : ypos + 9'd1;
    trigger  = 1'b0;
    trigAddr = '0;
    if (pix_ce && xpos[2:0] == 3'd4) begin
      if (grpNext < WPL_X && ypos < V_VIS_Y) begin
        trigger  = 1'b1;
        trigAddr = lineBase(ypos) + ADDR_W'(grpNext);
      end else if (xpos == LAST_TRIG_X && nextLine < V_VIS_Y) begin
        trigger  = 1'b1;
        trigAddr = lineBase(nextLine);
      end
    end
  end

  // A trigger seen while IDLE goes straight to SCAN_RD without waiting on scan_pend.
  assign scanPendAny = scanPend_q | trigger;
  assign pendAddr    = trigger ? trigAddr : scanAddr_q;
  assign hostInRange = (host_addr < NUM_WORDS_A);
  assign visible     = (xpos < H_VIS_X) && (ypos < V_VIS_Y);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scanPendAny) begin
          state_d = SCAN_RD;
        end else if (host_req) begin
          state_d = HOST_WR;
        end
      end
      SCAN_RD:  state_d = SCAN_LAT;
      SCAN_LAT: state_d = IDLE;
      HOST_WR:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // RAM-side outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ramAddr_d  = ramAddr_q;
    ramWe_d    = 1'b0;
    ramWdata_d = ramWdata_q;
    hostAck_d  = 1'b0;
    case (state_d)
      SCAN_RD: ramAddr_d = pendAddr;
      HOST_WR: begin
        ramAddr_d  = host_addr;
        ramWdata_d = host_data;
        ramWe_d    = hostInRange;
        hostAck_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    scanPend_d = scanPend_q;
    scanAddr_d = scanAddr_q;
    if (trigger) begin
      scanPend_d = 1'b1;
      scanAddr_d = trigAddr;
    end
    if (state_d == SCAN_RD) begin
      scanPend_d = 1'b0;
    end
    nextWord_d = (state_q == SCAN_LAT) ? ram_rdata : nextWord_q;
  end

  // Serialiser: group boundaries load the prefetched word, blanking forces black.
  always_comb begin
    pixel_d = pixel_q;
    shift_d = shift_q;
    if (pix_ce) begin
      if (!visible) begin
        pixel_d = 1'b0;
      end else if (xpos[2:0] == 3'd0) begin
        pixel_d = nextWord_q[7];
        shift_d = {nextWord_q[6:0], 1'b0};
      end else begin
        pixel_d = shift_q[7];
        shift_d = {shift_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      scanPend_q <= 1'b0;
      scanAddr_q <= '0;
      nextWord_q <= '0;
      shift_q    <= '0;
      pixel_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramWe_q    <= 1'b0;
      ramWdata_q <= '0;
      hostAck_q  <= 1'b0;
    end else begin
      scanPend_q <= scanPend_d;
      scanAddr_q <= scanAddr_d;
      nextWord_q <= nextWord_d;
      shift_q    <= shift_d;
      pixel_q    <= pixel_d;
      ramAddr_q  <= ramAddr_d;
      ramWe_q    <= ramWe_d;
      ramWdata_q <= ramWdata_d;
      hostAck_q  <= hostAck_d;
    end
  end

  assign pixel     = pixel_q;
  assign ram_addr  = ramAddr_q;
  assign ram_we    = ramWe_q;
  assign ram_wdata = ramWdata_q;
  assign host_ack  = hostAck_q;

endmodule
